fetch_queue_unit: RTL and testbench
===================================

FETCH_QUEUE_UNIT -- requirements
Module: fetch_queue_unit

Interface
REQ-001 Parameter PC_W, default 32, program-counter and fetch-address width.
REQ-002 Parameter INSTR_W, default 32, instruction width.
REQ-003 Parameter DEPTH, default 4, instruction-queue entries; power of two, at least 2.
REQ-004 Parameter RESET_PC, default 0, first fetch address after reset; low 2 bits zero.
REQ-005 clk  input  1  clock; all state updates on rising edge.
REQ-006 nrst  input  1  reset, synchronous, active-low.
REQ-007 redirect_valid  input  1  branch/jump redirect from decode.
REQ-008 redirect_pc  input  PC_W  redirect target.
REQ-009 ic_req  output  1  fetch request to I-cache controller.
REQ-010 ic_addr  output  PC_W  fetch address.
REQ-011 ic_gnt  input  1  request accepted this cycle.
REQ-012 ic_rvalid  input  1  response valid; never in the cycle of its own grant.
REQ-013 ic_rdata  input  INSTR_W  fetched instruction.
REQ-014 dec_valid  output  1  queue head valid.
REQ-015 dec_instr  output  INSTR_W  head instruction.
REQ-016 dec_pc  output  PC_W  head instruction PC.
REQ-017 dec_ready  input  1  decode consumes head.
REQ-018 occupancy  output  log2(DEPTH)+1  valid entries in queue.

Function
REQ-019 FSM states: IDLE (none outstanding), WAIT (one outstanding, live), DROP (one outstanding, stale); at most one request outstanding.
REQ-020 ic_req = 1 only in IDLE, when occupancy < DEPTH and redirect_valid = 0; ic_addr = fetch_pc.
REQ-021 ic_req and ic_addr held stable until ic_gnt, except a redirect, which withdraws the request that cycle.
REQ-022 IDLE -> WAIT on ic_req & ic_gnt.
REQ-023 WAIT, ic_rvalid: push {fetch_pc, ic_rdata} to queue tail; fetch_pc += 4 (mod 2^PC_W); -> IDLE.
REQ-024 Issue gating guarantees no push when full; push and pop in the same cycle leave occupancy unchanged.
REQ-025 Pop when dec_valid & dec_ready; dec_valid = (occupancy != 0); head outputs from registered queue storage.
REQ-026 Redirect (highest priority): flush queue (occupancy 0, push and pop suppressed); fetch_pc <= {redirect_pc[PC_W-1:2], 2'b00}.
REQ-027 Redirect in WAIT (including a cycle with ic_rvalid = 0) -> DROP; redirect in WAIT coincident with ic_rvalid discards the data -> IDLE.
REQ-028 Redirect in IDLE or DROP: stay in IDLE or DROP respectively.
REQ-029 DROP, ic_rvalid: discard data, no push, fetch_pc unchanged -> IDLE; request issues next cycle at the earliest.
REQ-030 Read/write pointers are log2(DEPTH) bits and wrap modulo DEPTH; occupancy counts 0..DEPTH.

Reset
REQ-031 nrst = 0: fetch_pc = RESET_PC, FSM = IDLE, pointers = 0, occupancy = 0.
REQ-032 Outputs during reset and the cycle after: ic_req = 0, dec_valid = 0; queue contents need not be cleared.
REQ-033 Reset mid-transaction abandons the outstanding request; the bench withholds ic_rvalid for it.

Verification
REQ-034 Reset release, ic_gnt = 1, response 1 cycle after grant, dec_ready = 1 -> ic_addr 0x0, 0x4, 0x8 in order; dec_pc matches; occupancy never exceeds 1.
REQ-035 dec_ready = 0, DEPTH = 4 -> exactly 4 pushes (PCs 0x0..0xC), occupancy = 4, ic_req stays 0; one pop -> one new request at 0x10.
REQ-036 Redirect to 0x103 while WAIT -> queue flushed, state DROP; stale ic_rdata not delivered; next ic_addr = 0x100.
REQ-037 Redirect coincident with dec_ready and ic_rvalid, occupancy 2 -> occupancy 0 next cycle; no push or pop.
REQ-038 ic_gnt held low 5 cycles -> ic_addr stable throughout; grant then response -> single push.
REQ-039 fetch_pc = 2^PC_W - 4, response -> fetch_pc wraps to 0; more than DEPTH push/pop cycles exercise pointer wrap in FIFO order.

Source files
------------

// File: rtl/fetch_queue_if.sv
// Bundle of the fetch unit's handshakes: decode redirect, I-cache request/response, decode queue head.
// master = the fetch unit itself, slave = its environment (I-cache, decode).
interface fetch_queue_if #(
  parameter int PC_W    = 32,
  parameter int INSTR_W = 32,
  parameter int DEPTH   = 4
);
  localparam int OCC_W = $clog2(DEPTH) + 1;

  logic               redirect_valid;
  logic [PC_W-1:0]    redirect_pc;
  logic               ic_req;
  logic [PC_W-1:0]    ic_addr;
  logic               ic_gnt;
  logic               ic_rvalid;
  logic [INSTR_W-1:0] ic_rdata;
  logic               dec_valid;
  logic [INSTR_W-1:0] dec_instr;
  logic [PC_W-1:0]    dec_pc;
  logic               dec_ready;
  logic [OCC_W-1:0]   occupancy;

  modport master (
    input  redirect_valid, redirect_pc, ic_gnt, ic_rvalid, ic_rdata, dec_ready,
    output ic_req, ic_addr, dec_valid, dec_instr, dec_pc, occupancy
  );

  modport slave (
    output redirect_valid, redirect_pc, ic_gnt, ic_rvalid, ic_rdata, dec_ready,
    input  ic_req, ic_addr, dec_valid, dec_instr, dec_pc, occupancy
  );
endinterface

// File: rtl/fetch_queue_unit.sv
// Instruction fetch unit: issues one I-cache request at a time and buffers returned
// instructions with their PCs in a small FIFO feeding decode; redirects flush everything.
module fetch_queue_unit #(
  parameter int              PC_W     = 32,
  parameter int              INSTR_W  = 32,
  parameter int              DEPTH    = 4,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic clk,
  input  logic nrst,
  fetch_queue_if.master fq
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

  state_t             state_reg;
  logic [PC_W-1:0]    fetch_pc_reg;
  logic [AW-1:0]      rd_ptr_reg;
  logic [AW-1:0]      wr_ptr_reg;
  logic [AW:0]        occ_reg;
  logic               started_reg;

  logic [PC_W-1:0]    pc_mem    [DEPTH];
  logic [INSTR_W-1:0] instr_mem [DEPTH];

  logic issue;
  logic push;
  logic pop;
  logic head_valid;

  // Issue only with guaranteed space, so a returning response can always be pushed.
  assign issue = nrst && started_reg && (state_reg == IDLE) && (occ_reg < FULL)
                 && !fq.redirect_valid;
  assign head_valid = nrst && (occ_reg != '0);
  assign push  = (state_reg == WAIT) && fq.ic_rvalid && !fq.redirect_valid;
  assign pop   = head_valid && fq.dec_ready && !fq.redirect_valid;

  assign fq.ic_req    = issue;
  assign fq.ic_addr   = fetch_pc_reg;
  assign fq.dec_valid = head_valid;
  assign fq.dec_pc    = pc_mem[rd_ptr_reg];
  assign fq.dec_instr = instr_mem[rd_ptr_reg];
  assign fq.occupancy = occ_reg;

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr_reg]    <= fetch_pc_reg;
      instr_mem[wr_ptr_reg] <= fq.ic_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_reg    <= IDLE;
      fetch_pc_reg <= RESET_PC;
      rd_ptr_reg   <= '0;
      wr_ptr_reg   <= '0;
      occ_reg      <= '0;
      started_reg  <= 1'b0;
    end else begin
      started_reg <= 1'b1;
      if (fq.redirect_valid) begin
        fetch_pc_reg <= fq.redirect_pc & ~PC_W'(3);
        rd_ptr_reg   <= '0;
        wr_ptr_reg   <= '0;
        occ_reg      <= '0;
        // A live request becomes stale; a response arriving now is simply dropped.
        case (state_reg)
          WAIT:    state_reg <= fq.ic_rvalid ? IDLE : DROP;
          DROP:    if (fq.ic_rvalid) state_reg <= IDLE;
          default: state_reg <= state_reg;
        endcase
      end else begin
        case (state_reg)
          IDLE: if (issue && fq.ic_gnt) state_reg <= WAIT;
          WAIT: if (fq.ic_rvalid) begin
            state_reg    <= IDLE;
            fetch_pc_reg <= fetch_pc_reg + PC_W'(4);
          end
          DROP: if (fq.ic_rvalid) state_reg <= IDLE;
          default: state_reg <= IDLE;
        endcase
        if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
        if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
        if (push && !pop)      occ_reg <= occ_reg + (AW+1)'(1);
        else if (pop && !push) occ_reg <= occ_reg - (AW+1)'(1);
      end
    end
  end
endmodule

// File: tb/tb_fetch_queue_unit.sv
// Randomized bench for fetch_queue_unit: a queue-based reference model predicts every
// delivered instruction; a separate monitor pops and compares what decode receives.
module tb_fetch_queue_unit;
  localparam int              PC_W     = 32;
  localparam int              INSTR_W  = 32;
  localparam int              DEPTH    = 4;
  localparam logic [PC_W-1:0] RESET_PC = '0;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } entry_t;
  typedef enum {M_NONE, M_LIVE, M_STALE} ost_e;

  logic clk = 1'b0;
  logic nrst = 1'b0;
  always #5 clk = ~clk;

  fetch_queue_if #(.PC_W(PC_W), .INSTR_W(INSTR_W), .DEPTH(DEPTH)) bus ();

  fetch_queue_unit #(.PC_W(PC_W), .INSTR_W(INSTR_W), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk  (clk),
    .nrst (nrst),
    .fq   (bus)
  );

  int tests = 0;
  int fails = 0;

  // stimulus knobs
  int gnt_pct = 100, rdy_pct = 100, redir_pct = 0, dly_lo = 1, dly_hi = 1;
  bit force_redir = 0;
  logic [PC_W-1:0] redir_tgt;

  // reference model
  entry_t          exp_q[$];
  logic [PC_W-1:0] model_pc = RESET_PC;
  ost_e            ost = M_NONE;
  bit              fresh = 1;
  int              rsp_cnt = 0;
  bit              mon_en = 0;

  // observations
  logic [PC_W-1:0] grant_log[$];
  logic            req_sample;
  logic [PC_W-1:0] addr_sample;
  int              occ_sample, occ_max;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    tests++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, want);
    end
  endtask

  task automatic tmo(input string name);
    tests++;
    fails++;
    $display("FAIL %s: timed out, got no event, expected one", name);
  endtask

  task automatic step(input bit rst_n);
    bit exp_req;
    @(negedge clk);
    nrst = rst_n;
    bus.redirect_valid = rst_n && ($urandom_range(99) < redir_pct);
    bus.redirect_pc    = $urandom();
    if (rst_n && force_redir) begin
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = redir_tgt;
      force_redir        = 0;
    end
    bus.ic_gnt    = ($urandom_range(99) < gnt_pct);
    bus.dec_ready = ($urandom_range(99) < rdy_pct);
    bus.ic_rvalid = 1'b0;
    bus.ic_rdata  = $urandom();
    if (rst_n && ost != M_NONE) begin
      if (rsp_cnt <= 1) bus.ic_rvalid = 1'b1;
      else rsp_cnt--;
    end
    #1;
    exp_req = rst_n && !fresh && (ost == M_NONE) && (exp_q.size() < DEPTH) && !bus.redirect_valid;
    chk("ic_req", bus.ic_req, exp_req);
    if (bus.ic_req) chk("ic_addr", bus.ic_addr, model_pc);
    req_sample  = bus.ic_req;
    addr_sample = bus.ic_addr;
    occ_sample  = int'(bus.occupancy);
    if (occ_sample > occ_max) occ_max = occ_sample;
    if (rst_n && bus.ic_req && bus.ic_gnt) grant_log.push_back(bus.ic_addr);
    #2;
    // model the effect of the coming rising edge
    if (!rst_n) begin
      exp_q.delete();
      model_pc = RESET_PC;
      ost      = M_NONE;
      fresh    = 1;
    end else begin
      fresh = 0;
      if (bus.redirect_valid) begin
        exp_q.delete();
        model_pc = {bus.redirect_pc[PC_W-1:2], 2'b00};
        if (bus.ic_rvalid) ost = M_NONE;
        else if (ost == M_LIVE) ost = M_STALE;
      end else if (bus.ic_rvalid) begin
        if (ost == M_LIVE) begin
          exp_q.push_back('{pc: model_pc, instr: bus.ic_rdata});
          model_pc = model_pc + 4;
        end
        ost = M_NONE;
      end
      if (bus.ic_req && bus.ic_gnt) begin
        ost     = M_LIVE;
        rsp_cnt = $urandom_range(dly_hi, dly_lo);
      end
    end
  endtask

  task automatic do_reset();
    repeat (2) step(1'b0);
    grant_log.delete();
    occ_max = 0;
  endtask

  // monitor: compares every instruction decode actually takes against the scoreboard
  initial begin : monitor
    entry_t e;
    forever begin
      @(negedge clk);
      #2;
      if (mon_en) begin
        chk("occupancy", bus.occupancy, exp_q.size());
        chk("dec_valid", bus.dec_valid, nrst && (exp_q.size() != 0));
        if (nrst && bus.dec_valid && bus.dec_ready && !bus.redirect_valid) begin
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL pop_empty: got dec_valid=1, expected empty queue");
          end else begin
            e = exp_q.pop_front();
            chk("dec_pc", bus.dec_pc, e.pc);
            chk("dec_instr", bus.dec_instr, e.instr);
          end
        end
      end
    end
  end

  initial begin : stimulus
    int n;
    bus.redirect_valid = 0; bus.redirect_pc = '0; bus.ic_gnt = 0;
    bus.ic_rvalid = 0; bus.ic_rdata = '0; bus.dec_ready = 0;
    step(1'b0);
    mon_en = 1;
    do_reset();

    // in-order fetch with immediate grant/response and eager decode
    gnt_pct = 100; rdy_pct = 100; dly_lo = 1; dly_hi = 1;
    repeat (12) step(1'b1);
    chk("A grant0", grant_log[0], 32'h0);
    chk("A grant1", grant_log[1], 32'h4);
    chk("A grant2", grant_log[2], 32'h8);
    chk("A occ_max", occ_max, 1);

    // decode stalled: queue fills, then one pop allows exactly one new request
    do_reset();
    rdy_pct = 0;
    repeat (20) step(1'b1);
    chk("B occupancy full", occ_sample, DEPTH);
    chk("B grants", grant_log.size(), 4);
    chk("B last pc", grant_log[3], 32'hC);
    chk("B ic_req full", req_sample, 0);
    rdy_pct = 100; step(1'b1);
    rdy_pct = 0; repeat (6) step(1'b1);
    chk("B grants after pop", grant_log.size(), 5);
    chk("B refill pc", grant_log[4], 32'h10);

    // redirect while a request is live: flush, drop stale data, refetch aligned target
    do_reset();
    dly_lo = 3; dly_hi = 3;
    n = 0;
    while (!(exp_q.size() >= 1 && ost == M_LIVE && rsp_cnt > 1) && n < 40) begin step(1'b1); n++; end
    if (n >= 40) tmo("C setup");
    n = grant_log.size();
    redir_tgt = 32'h103; force_redir = 1;
    step(1'b1);
    step(1'b1);
    chk("C flushed", occ_sample, 0);
    while (grant_log.size() <= n && grant_log.size() < n + 1 + 20) step(1'b1);
    if (grant_log.size() > n) chk("C redirect addr", grant_log[n], 32'h100);
    else tmo("C regrant");

    // redirect coincident with response and pop at occupancy 2
    do_reset();
    dly_lo = 2; dly_hi = 2;
    n = 0;
    while (!(exp_q.size() == 2 && ost == M_LIVE && rsp_cnt == 1) && n < 40) begin step(1'b1); n++; end
    if (n >= 40) tmo("D setup");
    chk("D occ before", occ_sample, 2);
    redir_tgt = 32'h200; force_redir = 1; rdy_pct = 100;
    step(1'b1);
    rdy_pct = 0; gnt_pct = 0;
    step(1'b1);
    chk("D occ after", occ_sample, 0);

    // grant withheld: request and address hold, then a single push
    do_reset();
    dly_lo = 1; dly_hi = 1;
    step(1'b1);
    for (int i = 0; i < 5; i++) begin
      step(1'b1);
      chk("E req held", req_sample, 1);
      chk("E addr held", addr_sample, RESET_PC);
    end
    gnt_pct = 100; step(1'b1);
    gnt_pct = 0; repeat (4) step(1'b1);
    chk("E grants", grant_log.size(), 1);
    chk("E single push", occ_sample, 1);

    // fetch_pc wraparound
    do_reset();
    gnt_pct = 100; rdy_pct = 100;
    redir_tgt = 32'hFFFF_FFFC; force_redir = 1;
    repeat (10) step(1'b1);
    chk("F grant top", grant_log[0], 32'hFFFF_FFFC);
    chk("F wrap0", grant_log[1], 32'h0);
    chk("F wrap4", grant_log[2], 32'h4);

    // random rounds, each entered through a reset that may abandon a live request
    for (int r = 0; r < 8; r++) begin
      n = 0;
      while (ost != M_LIVE && n < 50) begin step(1'b1); n++; end
      do_reset();
      gnt_pct   = $urandom_range(100, 30);
      rdy_pct   = $urandom_range(100, 20);
      redir_pct = $urandom_range(8, 0);
      dly_lo    = 1;
      dly_hi    = $urandom_range(4, 1);
      repeat (400) step(1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: got no completion, expected end of stimulus");
    $fatal(1, "watchdog expired");
  end
endmodule
